noc_ejection_sink: RTL
======================

Name: noc_ejection_sink

Overview:
- Local-port ejection endpoint of a mesh tile: receiving end of the router's local downstream req/ack link, the counterpart of the injecting traffic generator.
- Accepts flits from the Router local output into a small buffer and drains them under a consumer stall control.
- Checks packet framing and destination on drained flits, then publishes packet/flit/error statistics for the mesh bench and for on-chip debug.

Parameters:
- router_conf, '{xaddr:0,yaddr:0}, router_conf_t; this tile's mesh coordinates, compared against head-flit destination.
- FIFO_DEPTH, 4, ejection buffer depth in flits; power of two, >=2.
- CNT_W, 32, width of all statistics counters.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- i_flit  in  FLIT_t  flit from Router o_s2d[LOCAL_PORT].flit
- i_rec_req  in  1  Router o_downstream_req[LOCAL_PORT]; flit valid
- o_rec_ack  out  1  to Router i_downstream_ack[LOCAL_PORT]; buffer can accept
- i_stall  in  1  consumer backpressure; 1 = no drain this cycle
- o_pkt_done  out  1  one-cycle pulse, a tail or head_tail flit drained without error
- o_last_src  out  router_conf_t  source coordinates of the last completed packet
- o_pkt_count  out  CNT_W  packets completed
- o_flit_count  out  CNT_W  flits drained
- o_err_seq  out  CNT_W  framing errors
- o_err_route  out  CNT_W  misrouted head flits
- o_busy  out  1  FSM in IN_PKT or FIFO non-empty

Behaviour:
- Reset (async assert, sync release): FIFO empty; FSM IDLE; all counters 0; o_pkt_done 0; o_last_src 0; o_busy 0; o_rec_ack 1.
- Handshake:
  - Transfer occurs on a rising edge where i_rec_req=1 and o_rec_ack=1.
  - o_rec_ack = (occupancy < FIFO_DEPTH), derived only from registered occupancy; no combinational path from i_rec_req.
  - Full FIFO: ack 0, req may stay high and the flit is held upstream.
- Simultaneous push and pop:
  - Allowed when not full; occupancy unchanged.
  - When full, a same-cycle pop does not raise ack that cycle; ack rises the next cycle.
- Drain:
  - Pop on a rising edge when FIFO non-empty and i_stall=0; one flit per cycle.
  - Minimum latency: flit accepted at edge N is popped and counted at edge N+1.
- Checker FSM, on popped flits only:
  - IDLE + HEAD: check dst vs router_conf; mismatch increments o_err_route, packet still tracked; go IN_PKT; latch src.
  - IDLE + HEAD_TAIL: route check; on no error, pkt_count++, o_pkt_done, o_last_src update; stay IDLE.
  - IDLE + BODY/TAIL: err_seq++, flit discarded, stay IDLE.
  - IN_PKT + BODY: stay.
  - IN_PKT + TAIL: pkt_count++ and o_pkt_done if no error was recorded for this packet; go IDLE.
  - IN_PKT + HEAD/HEAD_TAIL: err_seq++, abandon current packet, process flit as if in IDLE.
- o_flit_count increments on every pop regardless of errors.
- Counters saturate at all-ones, no wrap.
- Reset mid-packet: FIFO contents lost; FSM to IDLE; counters cleared.

Optional Feature:
- SINK_LATENCY_EN defined:
  - Adds outputs o_lat_sum (CNT_W+16 bits) and o_lat_max (CNT_W bits), plus an internal free-running CNT_W cycle counter (wraps).
  - On each drained HEAD/HEAD_TAIL, latency = now - head payload[CNT_W-1:0] (modulo 2^CNT_W); accumulated into o_lat_sum (saturating) and into o_lat_max as a running maximum.
  - The generator stamps injection cycle into the head payload.
- Undefined: these ports and that logic are absent.

Decomposition:
- router_pkg:
  - Already holds FLIT_t, router_conf_t, port indices.
  - Gains flit type enum (HEAD, BODY, TAIL, HEAD_TAIL) and FLIT_t field accessors if missing.
  - Gains sink_state_t {IDLE, IN_PKT}.
- Sub-module ejection_fifo: parameterised synchronous FIFO with registered count, full, empty. Reusable by the router input buffers.

Test Plan:
- conf (1,2); one HEAD_TAIL dst (1,2) src (0,0), i_stall=0 -> ack at edge N, o_pkt_done at N+1, pkt_count=1, flit_count=1, o_last_src=(0,0).
- 4-flit packet HEAD, BODY, BODY, TAIL, back-to-back -> pkt_count=1, flit_count=4, single o_pkt_done on the TAIL pop, errors 0.
- i_stall=1, stream 6 flits -> 4 accepted, o_rec_ack=0 from the 4th accept, req held; release stall -> remaining 2 accepted; all 6 counted, none lost or duplicated.
- Framing errors: TAIL in IDLE -> err_seq=1; HEAD, BODY, HEAD, TAIL -> err_seq=2, pkt_count=1.
- HEAD dst (0,0) at tile (1,2), then TAIL -> err_route=1, pkt_count=0, no o_pkt_done.
- reset_n low while 3 flits buffered and FSM in IN_PKT -> immediately FIFO empty, IDLE, counters 0, ack=1.
- With SINK_LATENCY_EN: head stamped 100 and popped when cycle counter = 137 -> o_lat_max=37, o_lat_sum=37.

Source files
------------

// File: rtl/noc_ejection_sink_pkg.sv
// Shared router/ejection types: flit format, tile coordinates, port indices,
// flit-type encoding and the ejection checker state.
package noc_ejection_sink_pkg;

    localparam int unsigned COORD_W   = 4;
    localparam int unsigned PAYLOAD_W = 32;

    // Router port indices
    localparam int unsigned LOCAL_PORT = 0;
    localparam int unsigned NORTH_PORT = 1;
    localparam int unsigned EAST_PORT  = 2;
    localparam int unsigned SOUTH_PORT = 3;
    localparam int unsigned WEST_PORT  = 4;

    typedef struct packed {
        logic [COORD_W-1:0] xaddr;
        logic [COORD_W-1:0] yaddr;
    } router_conf_t;

    typedef enum logic [1:0] {
        HEAD      = 2'd0,
        BODY      = 2'd1,
        TAIL      = 2'd2,
        HEAD_TAIL = 2'd3
    } flit_type_t;

    typedef struct packed {
        flit_type_t             ftype;
        router_conf_t           dst;
        router_conf_t           src;
        logic [PAYLOAD_W-1:0]   payload;
    } FLIT_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } sink_state_t;

    function automatic flit_type_t flit_type(input FLIT_t f);
        return f.ftype;
    endfunction

    // HEAD and HEAD_TAIL both open a packet
    function automatic logic flit_is_head(input FLIT_t f);
        return (f.ftype == HEAD) || (f.ftype == HEAD_TAIL);
    endfunction

endpackage

// File: rtl/noc_ejection_sink_if.sv
// Router local downstream req/ack link into the ejection sink.
//   i_flit    : flit payload (router -> sink)
//   i_rec_req : flit valid   (router -> sink)
//   o_rec_ack : sink can accept (sink -> router)
interface noc_ejection_sink_if;
    import noc_ejection_sink_pkg::*;

    FLIT_t i_flit;
    logic  i_rec_req;
    logic  o_rec_ack;

    modport master (output i_flit, output i_rec_req, input  o_rec_ack);
    modport slave  (input  i_flit, input  i_rec_req, output o_rec_ack);
endinterface

// File: rtl/noc_ejection_sink_fifo.sv
// Synchronous FIFO with registered occupancy; full/empty decode the count.
// Ports: clk, reset_n (async active-low), push_i/din_i write side,
// pop_i/dout_o read side (dout_o shows the head entry), count_o, full_o, empty_o.
// Push while full and pop while empty are ignored. DEPTH must be a power of two >= 2.
module noc_ejection_sink_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == OCC_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_d = count_q + OCC_W'(do_push) - OCC_W'(do_pop);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy guards every read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/noc_ejection_sink.sv
// Local-port ejection endpoint: buffers flits from the router, drains them
// under i_stall, checks framing/destination and keeps saturating statistics.
// Ports: clk, reset_n (async active-low); link (slave: i_flit, i_rec_req, o_rec_ack);
// i_stall (1 = no drain); o_pkt_done pulse; o_last_src; o_pkt_count, o_flit_count,
// o_err_seq, o_err_route counters; o_busy.
// Optional macro SINK_LATENCY_EN adds o_lat_sum / o_lat_max head-flit latency stats.
module noc_ejection_sink import noc_ejection_sink_pkg::*; #(
    parameter router_conf_t router_conf = '{xaddr: '0, yaddr: '0},
    parameter int unsigned  FIFO_DEPTH  = 4,
    parameter int unsigned  CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    noc_ejection_sink_if.slave    link,
    input  logic                  i_stall,
    output logic                  o_pkt_done,
    output router_conf_t          o_last_src,
    output logic [CNT_W-1:0]      o_pkt_count,
    output logic [CNT_W-1:0]      o_flit_count,
    output logic [CNT_W-1:0]      o_err_seq,
    output logic [CNT_W-1:0]      o_err_route,
    output logic                  o_busy
`ifdef SINK_LATENCY_EN
   ,output logic [CNT_W+15:0]     o_lat_sum,
    output logic [CNT_W-1:0]      o_lat_max
`endif
);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

    FLIT_t              pop_flit;
    logic [OCC_W-1:0]   fifo_count;
    logic               fifo_full, fifo_empty;
    logic               push_c, pop_c;

    sink_state_t        state_q, state_d;
    logic               head_c, seq_err_c, route_err_c, done_c;
    logic               pkt_err_q;
    router_conf_t       pkt_src_q;

    // Ack depends only on registered occupancy, never on i_rec_req
    assign link.o_rec_ack = !fifo_full;
    assign push_c         = link.i_rec_req && !fifo_full;
    assign pop_c          = !fifo_empty && !i_stall;
    assign o_busy         = (state_q == IN_PKT) || (fifo_count != '0);

    noc_ejection_sink_fifo #(
        .WIDTH ($bits(FLIT_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_c),
        .din_i   (link.i_flit),
        .pop_i   (pop_c),
        .dout_o  (pop_flit),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Checker state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state: any head restarts a packet, tail/head_tail closes it, body holds
    always_comb begin
        state_d = state_q;
        if (pop_c) begin
            unique case (pop_flit.ftype)
                HEAD:            state_d = IN_PKT;
                TAIL, HEAD_TAIL: state_d = IDLE;
                default:         ;
            endcase
        end
    end

    // Checker events for the popped flit
    always_comb begin
        head_c      = 1'b0;
        seq_err_c   = 1'b0;
        route_err_c = 1'b0;
        done_c      = 1'b0;
        if (pop_c) begin
            head_c      = flit_is_head(pop_flit);
            route_err_c = head_c && (pop_flit.dst != router_conf);
            unique case (state_q)
                IDLE:    seq_err_c = !head_c;
                IN_PKT:  seq_err_c = head_c;
                default: ;
            endcase
            unique case (pop_flit.ftype)
                HEAD_TAIL: done_c = !route_err_c;
                TAIL:      done_c = (state_q == IN_PKT) && !pkt_err_q;
                default:   ;
            endcase
        end
    end

    // Per-packet tracking and statistics; counters saturate
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_err_q    <= 1'b0;
            pkt_src_q    <= '0;
            o_pkt_done   <= 1'b0;
            o_last_src   <= '0;
            o_pkt_count  <= '0;
            o_flit_count <= '0;
            o_err_seq    <= '0;
            o_err_route  <= '0;
        end else begin
            o_pkt_done <= done_c;
            if (head_c) begin
                pkt_err_q <= route_err_c;
                pkt_src_q <= pop_flit.src;
            end
            if (done_c) begin
                o_last_src <= (pop_flit.ftype == HEAD_TAIL) ? pop_flit.src : pkt_src_q;
            end
            if (done_c && (o_pkt_count != '1))   o_pkt_count  <= o_pkt_count + CNT_W'(1);
            if (pop_c && (o_flit_count != '1))   o_flit_count <= o_flit_count + CNT_W'(1);
            if (seq_err_c && (o_err_seq != '1))  o_err_seq    <= o_err_seq + CNT_W'(1);
            if (route_err_c && (o_err_route != '1)) o_err_route <= o_err_route + CNT_W'(1);
        end
    end

`ifdef SINK_LATENCY_EN
    localparam int unsigned LSUM_W = CNT_W + 16;
    localparam int unsigned LSUM_X = LSUM_W + 1;

    logic [CNT_W-1:0]  cyc_q;
    logic [CNT_W-1:0]  lat_c;
    logic [LSUM_W:0]   lat_sum_ext_c;

    // Head payload carries the injection cycle; difference wraps modulo 2^CNT_W
    assign lat_c         = cyc_q - pop_flit.payload[CNT_W-1:0];
    assign lat_sum_ext_c = {1'b0, o_lat_sum} + LSUM_X'(lat_c);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q     <= '0;
            o_lat_sum <= '0;
            o_lat_max <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (head_c) begin
                o_lat_sum <= lat_sum_ext_c[LSUM_W] ? '1 : lat_sum_ext_c[LSUM_W-1:0];
                if (lat_c > o_lat_max) o_lat_max <= lat_c;
            end
        end
    end
`else
    logic unused_payload_c;
    assign unused_payload_c = ^pop_flit.payload;
`endif

endmodule
